// File: rtl/sprite_blitter_if.sv
// sprite_blitter_if: sprite request inputs and pixel-writer outputs of sprite_blitter
interface sprite_blitter_if #(
  parameter int N_SPR = 4,
  parameter int NX = 10,
  parameter int NY = 9,
  parameter int CD = 9
);
  logic start;
  logic [N_SPR-1:0] spr_en;
  logic [N_SPR*NX-1:0] spr_x;
  logic [N_SPR*NY-1:0] spr_y;
  logic [N_SPR*CD-1:0] spr_color;
  logic busy;
  logic done;
  logic [NX-1:0] x;
  logic [NY-1:0] y;
  logic [CD-1:0] color;
  logic write;
  modport master (
    output start, spr_en, spr_x, spr_y, spr_color,
    input busy, done, x, y, color, write
  );
  modport slave (
    input start, spr_en, spr_x, spr_y, spr_color,
    output busy, done, x, y, color, write
  );
endinterface

// File: rtl/sprite_blitter.sv
// sprite_blitter: erases sprites at old positions, then draws enabled sprites, one pixel per clock
module sprite_blitter #(
  parameter RESOLUTION = "640x480",
  parameter int COLOR_DEPTH = 9,
  parameter int N_SPR = 4,
  parameter int W = 8,
  parameter int H = 8,
  parameter logic [COLOR_DEPTH-1:0] BG_COLOR = '0
) (
  input logic clock,
  input logic reset,
  sprite_blitter_if.slave bus
);
  localparam int NX = RESOLUTION == "320x240" ? 9 : RESOLUTION == "160x120" ? 8 : 10;
  localparam int NY = RESOLUTION == "320x240" ? 8 : RESOLUTION == "160x120" ? 7 : 9;
  localparam int XMAX = RESOLUTION == "320x240" ? 320 : RESOLUTION == "160x120" ? 160 : 640;
  localparam int YMAX = RESOLUTION == "320x240" ? 240 : RESOLUTION == "160x120" ? 120 : 480;
  localparam int CD = COLOR_DEPTH;
  localparam int IW = N_SPR > 1 ? $clog2(N_SPR) : 1;
  localparam int DW = $clog2(W + 1);
  localparam int DH = $clog2(H + 1);
  typedef enum logic [1:0] {IDLE, ERASE, DRAW, FIN} state_t;
  state_t state, state_n;
  logic [N_SPR-1:0] new_en, old_valid, rem, rem_n;
  logic [N_SPR*NX-1:0] new_x, old_x;
  logic [N_SPR*NY-1:0] new_y, old_y;
  logic [N_SPR*CD-1:0] new_color;
  logic [DW-1:0] dx;
  logic [DH-1:0] dy;
  logic [IW-1:0] cur;
  logic [NX-1:0] bx;
  logic [NY-1:0] by;
  logic [NX:0] sx;
  logic [NY:0] sy;
  logic erasing, emitting, last_px, accept, x_end, in_bounds;
  // rem holds the sprites still to visit in the current phase; cur is its lowest set bit,
  // so disabled/invalid sprites cost no cycles
  always_comb begin
    cur = '0;
    for (int k = N_SPR - 1; k >= 0; k--) if (rem[k]) cur = IW'(k);
    erasing = state == ERASE;
    emitting = state == ERASE || state == DRAW;
    accept = state == IDLE && bus.start;
    bx = erasing ? old_x[cur*NX +: NX] : new_x[cur*NX +: NX];
    by = erasing ? old_y[cur*NY +: NY] : new_y[cur*NY +: NY];
    sx = {1'b0, bx} + (NX+1)'(dx);
    sy = {1'b0, by} + (NY+1)'(dy);
    in_bounds = sx < (NX+1)'(XMAX) && sy < (NY+1)'(YMAX);
    x_end = dx == DW'(W - 1);
    last_px = x_end && dy == DH'(H - 1);
    rem_n = rem & ~(N_SPR'(1) << cur);
    state_n = state;
    case (state)
      IDLE: if (bus.start) state_n = |old_valid ? ERASE : |bus.spr_en ? DRAW : FIN;
      ERASE: if (last_px && rem_n == '0) state_n = |new_en ? DRAW : FIN;
      DRAW: if (last_px && rem_n == '0) state_n = FIN;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clock) state <= reset ? IDLE : state_n;
  always_ff @(posedge clock) begin
    if (reset) begin
      new_en <= '0;
      new_x <= '0;
      new_y <= '0;
      new_color <= '0;
      old_valid <= '0;
      old_x <= '0;
      old_y <= '0;
      rem <= '0;
      dx <= '0;
      dy <= '0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.write <= 1'b0;
      bus.x <= '0;
      bus.y <= '0;
      bus.color <= '0;
    end else begin
      bus.write <= 1'b0;
      bus.done <= 1'b0;
      if (accept) begin
        new_en <= bus.spr_en;
        new_x <= bus.spr_x;
        new_y <= bus.spr_y;
        new_color <= bus.spr_color;
        rem <= |old_valid ? old_valid : bus.spr_en;
        dx <= '0;
        dy <= '0;
        bus.busy <= 1'b1;
      end
      // clipped pixels still take their cycle but never strobe write
      if (emitting) begin
        bus.write <= in_bounds;
        bus.x <= sx[NX-1:0];
        bus.y <= sy[NY-1:0];
        bus.color <= erasing ? BG_COLOR : new_color[cur*CD +: CD];
        dx <= x_end ? '0 : dx + 1'b1;
        dy <= last_px ? '0 : x_end ? dy + 1'b1 : dy;
        if (last_px) rem <= (erasing && rem_n == '0) ? new_en : rem_n;
      end
      if (state == FIN) begin
        old_x <= new_x;
        old_y <= new_y;
        old_valid <= new_en;
        bus.done <= 1'b1;
        bus.busy <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_sprite_blitter.sv
// tb_sprite_blitter: randomized and directed checks of sprite_blitter against a pixel-list model
module tb_sprite_blitter;
  localparam int N = 2, W = 2, H = 2, NX = 8, NY = 7, CD = 9, XMAX = 160, YMAX = 120;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  sprite_blitter_if #(.N_SPR(N), .NX(NX), .NY(NY), .CD(CD)) bus();
  sprite_blitter #(.RESOLUTION("160x120"), .COLOR_DEPTH(CD), .N_SPR(N), .W(W), .H(H), .BG_COLOR(9'd0))
    dut (.clock(clk), .reset(rst), .bus(bus));
  typedef struct {bit busy; bit done; bit wr; int x; int y; int c;} rec_t;
  rec_t q[$];
  int checks = 0, errors = 0, cyc = 0;
  int m_ox[N], m_oy[N];
  bit [N-1:0] m_ov;
  logic [CD-1:0] fb [XMAX*YMAX];
  bit armed = 0;
  task automatic chk(string name, int got, int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask
  task automatic push_rect(int bx, int by, int c);
    for (int j = 0; j < H; j++)
      for (int i = 0; i < W; i++) begin
        rec_t r;
        r.busy = 1; r.done = 0; r.x = bx + i; r.y = by + j; r.c = c;
        r.wr = (r.x < XMAX) && (r.y < YMAX);
        q.push_back(r);
      end
  endtask
  // expected visible output sequence of one pass: a busy cycle, every pixel slot, the done cycle
  task automatic accept(logic [N-1:0] en, logic [N*NX-1:0] xs, logic [N*NY-1:0] ys, logic [N*CD-1:0] cs);
    rec_t r;
    r.busy = 1; r.done = 0; r.wr = 0; r.x = 0; r.y = 0; r.c = 0;
    q.push_back(r);
    for (int i = 0; i < N; i++) if (m_ov[i]) push_rect(m_ox[i], m_oy[i], 0);
    for (int i = 0; i < N; i++) if (en[i]) push_rect(int'(xs[i*NX +: NX]), int'(ys[i*NY +: NY]), int'(cs[i*CD +: CD]));
    r.busy = 0; r.done = 1;
    q.push_back(r);
    for (int i = 0; i < N; i++) begin
      m_ox[i] = int'(xs[i*NX +: NX]);
      m_oy[i] = int'(ys[i*NY +: NY]);
    end
    m_ov = en;
  endtask
  initial begin : monitor
    rec_t e;
    forever begin
      @(posedge clk);
      if (rst) begin
        q.delete();
        m_ov = '0;
        armed = 1;
      end else if (bus.start && q.size() == 0) accept(bus.spr_en, bus.spr_x, bus.spr_y, bus.spr_color);
      #1;
      cyc++;
      if (armed) begin
        e.busy = 0; e.done = 0; e.wr = 0; e.x = 0; e.y = 0; e.c = 0;
        if (q.size() > 0) e = q.pop_front();
        checks++;
        if (bus.busy !== e.busy || bus.done !== e.done || bus.write !== e.wr ||
            (e.wr && (int'(bus.x) != e.x || int'(bus.y) != e.y || int'(bus.color) != e.c))) begin
          errors++;
          $display("FAIL cycle %0d: got busy=%b done=%b write=%b x=%0d y=%0d color=%h, expected busy=%b done=%b write=%b x=%0d y=%0d color=%h",
                   cyc, bus.busy, bus.done, bus.write, bus.x, bus.y, bus.color, e.busy, e.done, e.wr, e.x, e.y, e.c);
        end
        if (bus.write === 1'b1 && bus.x < XMAX && bus.y < YMAX) fb[bus.y*XMAX + bus.x] = bus.color;
      end
    end
  end
  task automatic drive(logic [N-1:0] en, int x0, int y0, int c0, int x1, int y1, int c1);
    bus.spr_en = en;
    bus.spr_x = {NX'(x1), NX'(x0)};
    bus.spr_y = {NY'(y1), NY'(y0)};
    bus.spr_color = {CD'(c1), CD'(c0)};
  endtask
  task automatic run_pass(int hold, output int lat, output int nwr, output int nzero, output int ndone,
                          output int nbusy, output int fx, output int fy, output int fc);
    lat = -1; nwr = 0; nzero = 0; ndone = 0; nbusy = 0; fx = -1; fy = -1; fc = -1;
    bus.start = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k >= hold) bus.start = 1'b0;
      if (bus.done) begin
        ndone++;
        if (lat < 0) lat = k;
      end
      if (bus.busy) nbusy++;
      if (bus.write) begin
        if (nwr == 0) begin
          fx = int'(bus.x); fy = int'(bus.y); fc = int'(bus.color);
        end
        nwr++;
        if (bus.color == '0) nzero++;
      end
    end
  endtask
  initial begin
    int lat, nwr, nzero, ndone, nbusy, fx, fy, fc;
    bus.start = 1'b0;
    drive('0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    chk("reset busy", int'(bus.busy), 0);
    chk("reset done", int'(bus.done), 0);
    chk("reset write", int'(bus.write), 0);
    chk("reset x", int'(bus.x), 0);
    chk("reset y", int'(bus.y), 0);
    chk("reset color", int'(bus.color), 0);
    rst = 1'b0;
    drive(2'b01, 10, 20, 'h1C0, 0, 0, 0);
    run_pass(1, lat, nwr, nzero, ndone, nbusy, fx, fy, fc);
    chk("t1 latency", lat, 6);
    chk("t1 writes", nwr, 4);
    chk("t1 busy cycles", nbusy, 5);
    chk("t1 done pulses", ndone, 1);
    chk("t1 first x", fx, 10);
    chk("t1 first y", fy, 20);
    chk("t1 first color", fc, 'h1C0);
    drive(2'b01, 12, 20, 'h1C0, 0, 0, 0);
    run_pass(1, lat, nwr, nzero, ndone, nbusy, fx, fy, fc);
    chk("t2 latency", lat, 10);
    chk("t2 writes", nwr, 8);
    chk("t2 erase writes", nzero, 4);
    chk("t2 first x", fx, 10);
    chk("t2 first color", fc, 0);
    chk("t2 fb 13,21", int'(fb[21*XMAX + 13]), 'h1C0);
    chk("t2 fb 10,20 erased", int'(fb[20*XMAX + 10]), 0);
    drive(2'b10, 0, 0, 0, 159, 119, 'h03F);
    run_pass(1, lat, nwr, nzero, ndone, nbusy, fx, fy, fc);
    chk("t3 latency", lat, 10);
    chk("t3 writes", nwr, 5);
    chk("t3 fb corner", int'(fb[119*XMAX + 159]), 'h03F);
    drive(2'b01, 10, 20, 'h1C0, 0, 0, 0);
    run_pass(10, lat, nwr, nzero, ndone, nbusy, fx, fy, fc);
    chk("t4 done pulses", ndone, 1);
    chk("t4 latency", lat, 10);
    chk("t4 writes", nwr, 5);
    drive(2'b11, 30, 30, 1, 40, 40, 2);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (5) @(negedge clk);
    chk("t5 drawing before reset", int'(bus.write), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("t5 write after reset", int'(bus.write), 0);
    chk("t5 busy after reset", int'(bus.busy), 0);
    rst = 1'b0;
    drive(2'b00, 0, 0, 0, 0, 0, 0);
    run_pass(1, lat, nwr, nzero, ndone, nbusy, fx, fy, fc);
    chk("t5 empty latency", lat, 2);
    chk("t5 empty writes", nwr, 0);
    drive(2'b11, 50, 50, 'h1FF, 50, 50, 'h007);
    run_pass(1, lat, nwr, nzero, ndone, nbusy, fx, fy, fc);
    chk("t6 latency", lat, 10);
    chk("t6 writes", nwr, 8);
    chk("t6 overlap 50,50", int'(fb[50*XMAX + 50]), 'h007);
    chk("t6 overlap 51,51", int'(fb[51*XMAX + 51]), 'h007);
    drive(2'b00, 0, 0, 0, 0, 0, 0);
    run_pass(1, lat, nwr, nzero, ndone, nbusy, fx, fy, fc);
    chk("t6 erase latency", lat, 10);
    chk("t6 erase zero writes", nzero, 8);
    chk("t6 erased 50,50", int'(fb[50*XMAX + 50]), 0);
    repeat (3000) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        bus.spr_en[i] = 1'($urandom_range(0, 1));
        bus.spr_x[i*NX +: NX] = NX'($urandom_range(0, 9) == 0 ? $urandom_range(150, 255) : $urandom_range(0, 159));
        bus.spr_y[i*NY +: NY] = NY'($urandom_range(0, 9) == 0 ? $urandom_range(110, 127) : $urandom_range(0, 119));
        bus.spr_color[i*CD +: CD] = CD'($urandom);
      end
      bus.start = $urandom_range(0, 3) == 0;
      rst = $urandom_range(0, 599) == 0;
    end
    @(negedge clk);
    rst = 1'b0;
    bus.start = 1'b0;
    repeat (30) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
